sdram_port_arbiter: RTL

- Shares the single SDRAM (via the existing sdram controller core interface) among three requesters:
  - port 0: ROM download writer from data_io;
  - port 1: CPU ROM/RAM;
  - port 2: CD/ADPCM buffer.
- Also schedules periodic auto-refresh.
- Sits between the TGFX16 core memory clients and the SDRAM controller, inside the shared top, in the clk_sys domain.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/sdram_port_arbiter_rr_pick2.sv | 24 ++
 rtl/sdram_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, transaction owners
// and the number of client ports.
package sdram_arb_pkg;

  localparam int NUM_PORTS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_P0   = 2'd0,
    OWN_P1   = 2'd1,
    OWN_P2   = 2'd2,
    OWN_RFSH = 2'd3
  } owner_t;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick2.sv
// Round-robin selector between the two fair-share ports (CPU and CD buffer).
// Looks at which of the two was served last and prefers the other one.
module rr_pick2
  import sdram_arb_pkg::*;
(
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic [1:0] rr_last,
  output logic       pick_valid,
  output logic       pick_p2
);

  // Prefer port 2 only when port 1 had the previous turn; otherwise port 1 first
  always_comb begin
    pick_valid = p1_req | p2_req;
    pick_p2    = 1'b0;
    if (rr_last == OWN_P1) begin
      pick_p2 = p2_req;
    end else begin
      pick_p2 = p2_req & ~p1_req;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller between the ROM download writer (port 0), the
// CPU (port 1) and the CD/ADPCM buffer (port 2), and slots in periodic
// auto-refresh. One command is in flight at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int REFRESH_CYCLES = 780,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_din,
  input  logic [DATA_W/8-1:0]   p0_be,
  output logic                  p0_ack,
  output logic [DATA_W-1:0]     p0_dout,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_din,
  input  logic [DATA_W/8-1:0]   p1_be,
  output logic                  p1_ack,
  output logic [DATA_W-1:0]     p1_dout,
  input  logic                  p2_req,
  input  logic                  p2_we,
  input  logic [ADDR_W-1:0]     p2_addr,
  input  logic [DATA_W-1:0]     p2_din,
  input  logic [DATA_W/8-1:0]   p2_be,
  output logic                  p2_ack,
  output logic [DATA_W-1:0]     p2_dout,
  output logic                  mem_req,
  output logic                  mem_rfsh,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic                  timeout_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int RFSH_W = $clog2(REFRESH_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t state, state_next;
  owner_t     owner, rr_last, grant_owner;

  logic              grant_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [BE_W-1:0]   sel_be;

  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_din;
  logic [BE_W-1:0]   cmd_be;

  logic [RFSH_W-1:0] rfsh_cnt;
  logic              rfsh_pending;
  logic              rfsh_wrap;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              rr_valid, rr_p2;
  logic [NUM_PORTS-1:0] ack_vec;

  assign rfsh_wrap = (rfsh_cnt == RFSH_W'(REFRESH_CYCLES - 1));
  // The counter is cleared in ISSUE, so this marks the TIMEOUT_CYCLES-th WAIT cycle
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  rr_pick2 u_rr (
    .p1_req     (p1_req),
    .p2_req     (p2_req),
    .rr_last    (rr_last),
    .pick_valid (rr_valid),
    .pick_p2    (rr_p2)
  );

  // Fixed-priority grant: refresh, then the download port, then the fair pair
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_P0;
    sel_we      = 1'b0;
    sel_addr    = '0;
    sel_din     = '0;
    sel_be      = '0;
    if (rfsh_pending) begin
      grant_valid = 1'b1;
      grant_owner = OWN_RFSH;
    end else if (p0_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_P0;
      sel_we      = p0_we;
      sel_addr    = p0_addr;
      sel_din     = p0_din;
      sel_be      = p0_be;
    end else if (rr_valid) begin
      grant_valid = 1'b1;
      if (rr_p2) begin
        grant_owner = OWN_P2;
        sel_we      = p2_we;
        sel_addr    = p2_addr;
        sel_din     = p2_din;
        sel_be      = p2_be;
      end else begin
        grant_owner = OWN_P1;
        sel_we      = p1_we;
        sel_addr    = p1_addr;
        sel_din     = p1_din;
        sel_be      = p1_be;
      end
    end
  end

  // Next-state logic and the strobes, which are pure decodes of state and owner
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_rfsh   = 1'b0;
    ack_vec    = '0;
    case (state)
      IDLE:  if (grant_valid) state_next = ISSUE;
      ISSUE: begin
        state_next = WAIT;
        if (owner == OWN_RFSH) mem_rfsh = 1'b1;
        else                   mem_req  = 1'b1;
      end
      WAIT:  if (mem_ready || tmo_hit) state_next = DONE;
      DONE:  begin
        state_next = IDLE;
        if (owner != OWN_RFSH) ack_vec[owner] = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign p0_ack   = ack_vec[0];
  assign p1_ack   = ack_vec[1];
  assign p2_ack   = ack_vec[2];
  assign mem_we   = cmd_we;
  assign mem_addr = cmd_addr;
  assign mem_din  = cmd_din;
  assign mem_be   = cmd_be;

  // State register; reset aborts any transaction without an ack
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Latch the winner's command on grant so the controller sees it stable until DONE
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_P0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_din  <= '0;
      cmd_be   <= '0;
    end else if (state == IDLE && grant_valid) begin
      owner    <= grant_owner;
      cmd_we   <= sel_we;
      cmd_addr <= sel_addr;
      cmd_din  <= sel_din;
      cmd_be   <= sel_be;
    end
  end

  // Free-running refresh interval; a new interval's request wins over the clear
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rfsh_cnt     <= '0;
      rfsh_pending <= 1'b0;
    end else begin
      rfsh_cnt <= rfsh_wrap ? '0 : rfsh_cnt + 1'b1;
      if (rfsh_wrap)                                   rfsh_pending <= 1'b1;
      else if (state == ISSUE && owner == OWN_RFSH)    rfsh_pending <= 1'b0;
    end
  end

  // Watchdog on the controller; a late mem_ready in the expiry cycle still wins
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (!mem_ready && tmo_hit) timeout_err <= 1'b1;
    end
  end

  // Read data lands in the owning port's register and holds until its next read
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p0_dout <= '0;
      p1_dout <= '0;
      p2_dout <= '0;
    end else if (state == WAIT && mem_ready && !cmd_we) begin
      case (owner)
        OWN_P0:  p0_dout <= mem_dout;
        OWN_P1:  p1_dout <= mem_dout;
        OWN_P2:  p2_dout <= mem_dout;
        default: ;
      endcase
    end
  end

  // Remember which fair-share port was served last; port 1 gets the first turn
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rr_last <= OWN_P2;
    end else if (state == DONE && (owner == OWN_P1 || owner == OWN_P2)) begin
      rr_last <= owner;
    end
  end

endmodule
